// File: rtl/dkong_pkg.sv
// dkong_pkg
//   Shared definitions for the video-subsystem blocks.
//   - dma_state_e : object-RAM copy engine sequencer states
//   - OBJ_*       : default transfer length and RAM address widths
package dkong_pkg;

  localparam int OBJ_DMA_LEN = 384;
  localparam int OBJ_SRC_AW  = 10;
  localparam int OBJ_DST_AW  = 9;

  typedef enum logic [2:0] {
    DMA_IDLE   = 3'd0,
    DMA_REQ    = 3'd1,
    DMA_XFER   = 3'd2,
    DMA_DRAIN  = 3'd3,
    DMA_PDRAIN = 3'd4,
    DMA_DONE   = 3'd5
  } dma_state_e;

endpackage

// File: rtl/dkong_obj_dma.sv
// dkong_obj_dma
//   Object-RAM copy engine. A rising edge on I_START (accepted only while
//   idle) requests the CPU bus, and once granted streams LEN bytes from the
//   CPU work RAM into the sprite source RAM at one byte per clock, then
//   releases the bus and pulses O_DONE.
//
// Ports
//   I_CLK, I_RSTn          clock, async active-low reset
//   I_START                frame-start level (rising edge triggers)
//   I_SRC_BASE             first source address, latched on accepted edge
//   O_BUSRQ / I_BUSAK      CPU bus request / grant
//   O_SRC_ADDR, O_SRC_CE   source RAM read port
//   I_SRC_D                source RAM data (registered, zero while CE low)
//   O_DST_ADDR, O_DST_D,
//   O_DST_CE, O_DST_WE     destination RAM write port
//   O_BUSY                 high from accepted edge until release
//   O_DONE                 one-cycle completion pulse
//
// All outputs are registered except O_DST_D, which is a straight
// pass-through of the source RAM data.
module dkong_obj_dma #(
  parameter int LEN    = dkong_pkg::OBJ_DMA_LEN,
  parameter int SRC_AW = dkong_pkg::OBJ_SRC_AW,
  parameter int DST_AW = dkong_pkg::OBJ_DST_AW
) (
  input  logic              I_CLK,
  input  logic              I_RSTn,
  input  logic              I_START,
  input  logic [SRC_AW-1:0] I_SRC_BASE,
  output logic              O_BUSRQ,
  input  logic              I_BUSAK,
  output logic [SRC_AW-1:0] O_SRC_ADDR,
  output logic              O_SRC_CE,
  input  logic [7:0]        I_SRC_D,
  output logic [DST_AW-1:0] O_DST_ADDR,
  output logic [7:0]        O_DST_D,
  output logic              O_DST_CE,
  output logic              O_DST_WE,
  output logic              O_BUSY,
  output logic              O_DONE
);
  import dkong_pkg::*;

  localparam int               CNT_W = DST_AW + 1;
  localparam logic [CNT_W-1:0] LEN_C = CNT_W'(LEN);

  dma_state_e        state;
  logic              start_q;
  logic              start_rise;
  logic [SRC_AW-1:0] base;
  // rd_cnt counts reads already issued (including the one on the bus this
  // cycle); wr_cnt counts writes already scheduled. wr_cnt <= rd_cnt.
  logic [CNT_W-1:0]  rd_cnt;
  logic [CNT_W-1:0]  wr_cnt;

  assign start_rise = I_START & ~start_q;

  // Source RAM output is registered, so the byte addressed in cycle n is on
  // I_SRC_D in cycle n+1 -- exactly when the write side wants it.
  assign O_DST_D = I_SRC_D;

  // Outputs are computed for the *next* cycle alongside the state change,
  // so each state's outputs are visible during the cycle spent in it.
  always_ff @(posedge I_CLK or negedge I_RSTn) begin
    if (!I_RSTn) begin
      state      <= DMA_IDLE;
      start_q    <= 1'b0;
      base       <= '0;
      rd_cnt     <= '0;
      wr_cnt     <= '0;
      O_BUSRQ    <= 1'b0;
      O_SRC_ADDR <= '0;
      O_SRC_CE   <= 1'b0;
      O_DST_ADDR <= '0;
      O_DST_CE   <= 1'b0;
      O_DST_WE   <= 1'b0;
      O_BUSY     <= 1'b0;
      O_DONE     <= 1'b0;
    end else begin
      start_q    <= I_START;
      O_DONE     <= 1'b0;
      O_DST_CE   <= 1'b0;
      O_DST_WE   <= 1'b0;
      O_DST_ADDR <= '0;

      case (state)
        DMA_IDLE: begin
          // Edges in any other state are simply dropped.
          if (start_rise) begin
            base    <= I_SRC_BASE;
            rd_cnt  <= '0;
            wr_cnt  <= '0;
            O_BUSRQ <= 1'b1;
            O_BUSY  <= 1'b1;
            state   <= DMA_REQ;
          end
        end

        DMA_REQ: begin
          // Also the resume point after a lost grant: rd_cnt picks up at the
          // first byte not yet read.
          if (I_BUSAK) begin
            O_SRC_CE   <= 1'b1;
            O_SRC_ADDR <= base + SRC_AW'(rd_cnt);
            rd_cnt     <= rd_cnt + 1'b1;
            state      <= DMA_XFER;
          end
        end

        DMA_XFER: begin
          // The byte read this cycle is written next cycle.
          O_DST_CE   <= 1'b1;
          O_DST_WE   <= 1'b1;
          O_DST_ADDR <= DST_AW'(wr_cnt);
          wr_cnt     <= wr_cnt + 1'b1;
          // Last read wins over a lost grant: finishing needs no more bus.
          if (rd_cnt == LEN_C) begin
            state <= DMA_DRAIN;
          end else if (!I_BUSAK) begin
            state <= DMA_PDRAIN;
          end else begin
            O_SRC_ADDR <= base + SRC_AW'(rd_cnt);
            rd_cnt     <= rd_cnt + 1'b1;
          end
          // O_SRC_CE and O_SRC_ADDR are left untouched when leaving XFER so
          // the source keeps presenting the in-flight byte during its write;
          // the source wrapper would otherwise force the data to 0.
        end

        DMA_DRAIN: begin
          O_SRC_CE   <= 1'b0;
          O_SRC_ADDR <= '0;
          O_BUSRQ    <= 1'b0;
          O_DONE     <= 1'b1;
          state      <= DMA_DONE;
        end

        DMA_PDRAIN: begin
          // Bus request stays up; go back and wait for the grant again.
          O_SRC_CE   <= 1'b0;
          O_SRC_ADDR <= '0;
          state      <= DMA_REQ;
        end

        DMA_DONE: begin
          O_BUSY <= 1'b0;
          state  <= DMA_IDLE;
        end

        default: begin
          O_BUSRQ    <= 1'b0;
          O_SRC_CE   <= 1'b0;
          O_SRC_ADDR <= '0;
          O_BUSY     <= 1'b0;
          state      <= DMA_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dkong_obj_dma.sv
// tb_dkong_obj_dma
//   Self-checking bench for dkong_obj_dma. A source RAM model (registered
//   output, zeroed while CE is low) feeds the DUT; destination writes are
//   captured into dst_mem. Expected results come from the transfer rules:
//   dest[i] = src[(base+i) mod 1024], each destination address written once,
//   completion LEN+2 cycles after the (last) grant is sampled.
module tb_dkong_obj_dma;
  import dkong_pkg::*;

  localparam int LEN = OBJ_DMA_LEN;

  logic       I_CLK = 1'b0;
  logic       I_RSTn;
  logic       I_START;
  logic [9:0] I_SRC_BASE;
  logic       O_BUSRQ;
  logic       I_BUSAK;
  logic [9:0] O_SRC_ADDR;
  logic       O_SRC_CE;
  logic [7:0] I_SRC_D;
  logic [8:0] O_DST_ADDR;
  logic [7:0] O_DST_D;
  logic       O_DST_CE;
  logic       O_DST_WE;
  logic       O_BUSY;
  logic       O_DONE;

  logic [7:0] src_mem [1024];
  logic [7:0] src_q;
  logic [7:0] dst_mem [512];

  int checks = 0;
  int errors = 0;

  dkong_obj_dma #(.LEN(LEN), .SRC_AW(10), .DST_AW(9)) dut (
    .I_CLK      (I_CLK),
    .I_RSTn     (I_RSTn),
    .I_START    (I_START),
    .I_SRC_BASE (I_SRC_BASE),
    .O_BUSRQ    (O_BUSRQ),
    .I_BUSAK    (I_BUSAK),
    .O_SRC_ADDR (O_SRC_ADDR),
    .O_SRC_CE   (O_SRC_CE),
    .I_SRC_D    (I_SRC_D),
    .O_DST_ADDR (O_DST_ADDR),
    .O_DST_D    (O_DST_D),
    .O_DST_CE   (O_DST_CE),
    .O_DST_WE   (O_DST_WE),
    .O_BUSY     (O_BUSY),
    .O_DONE     (O_DONE)
  );

  always #5 I_CLK = ~I_CLK;

  // Source RAM: registered read, output forced to 0 whenever CE is low.
  always @(posedge I_CLK) if (O_SRC_CE) src_q <= src_mem[O_SRC_ADDR];
  assign I_SRC_D = O_SRC_CE ? src_q : 8'h00;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({O_BUSRQ, O_SRC_ADDR, O_SRC_CE, O_DST_ADDR, O_DST_D,
                O_DST_CE, O_DST_WE, O_BUSY, O_DONE});
  endfunction

  // One transfer. Cycle 0 is the cycle in which the start edge is sampled.
  // gdelay: cycles between O_BUSRQ appearing and the grant.
  // drop_at/drop_len: grant removed in the cycle byte drop_at is read.
  // spur: second start edge during the copy. rst_at: reset while reading
  // that byte (the task then ends early).
  task automatic run_xfer(input string name, input logic [9:0] base, input int gdelay,
                          input int drop_at, input int drop_len, input bit spur,
                          input int rst_at);
    int         wcnt [512];
    int         k, d, regrant, exp_done, t, nwr, ndone, done_t, first_rd, early_ce, dup, bad;
    logic [9:0] first_addr, sa;
    logic       done_busrq, done_busy, after_busy;
    bit         seen_done;

    for (int i = 0; i < 512; i++) begin
      wcnt[i]    = 0;
      dst_mem[i] = 8'h00;
    end
    k = 1 + gdelay;
    d = k + 1 + drop_at;
    if (drop_at < 0 || drop_at >= LEN - 1) begin
      exp_done = k + LEN + 2;
    end else begin
      regrant  = (drop_len > 2) ? d + drop_len : d + 2;
      exp_done = regrant + (LEN - 1 - drop_at) + 2;
    end
    nwr = 0; ndone = 0; done_t = -1; first_rd = -1; early_ce = 0;
    first_addr = '0; done_busrq = 1'b1; done_busy = 1'b0; after_busy = 1'b1;
    seen_done = 1'b0;

    @(negedge I_CLK);
    I_SRC_BASE = base;
    I_START    = 1'b1;
    t = 0;
    while (t < exp_done + 3 && t < 3000) begin
      @(negedge I_CLK);
      t++;
      if (t == 1) begin
        check({name, " busrq_lat"}, 64'(O_BUSRQ), 64'd1);
        check({name, " busy_lat"},  64'(O_BUSY),  64'd1);
      end
      if (t == 2) I_START = 1'b0;
      if (O_SRC_CE) begin
        if (t <= k) early_ce++;
        if (first_rd < 0) begin
          first_rd   = t;
          first_addr = O_SRC_ADDR;
        end
      end
      if (O_DST_CE && O_DST_WE) begin
        dst_mem[O_DST_ADDR] = O_DST_D;
        wcnt[O_DST_ADDR]++;
        nwr++;
      end
      if (O_DONE) begin
        ndone++;
        if (!seen_done) begin
          done_t     = t;
          done_busrq = O_BUSRQ;
          done_busy  = O_BUSY;
        end
        seen_done = 1'b1;
      end
      if (seen_done && t == done_t + 1) after_busy = O_BUSY;
      if (spur && t == k + 50) I_START = 1'b1;
      if (spur && t == k + 52) I_START = 1'b0;
      I_BUSAK = (t >= k) && !seen_done && !(drop_at >= 0 && t >= d && t < d + drop_len);

      if (rst_at >= 0 && t == k + 1 + rst_at) begin
        I_RSTn = 1'b0;
        #1;
        check({name, " rst_busrq"}, 64'(O_BUSRQ), 64'd0);
        check({name, " rst_outs"},  all_outs(),   64'd0);
        I_BUSAK = 1'b0;
        repeat (3) @(negedge I_CLK);
        check({name, " rst_hold"}, all_outs(), 64'd0);
        I_RSTn = 1'b1;
        return;
      end
    end
    I_BUSAK = 1'b0;

    check({name, " first_rd_cyc"}, 64'(first_rd),   64'(k + 1));
    check({name, " first_addr"},   64'(first_addr), 64'(base));
    check({name, " ce_before_gnt"}, 64'(early_ce),  64'd0);
    check({name, " done_count"},   64'(ndone),      64'd1);
    check({name, " done_cyc"},     64'(done_t),     64'(exp_done));
    check({name, " done_busrq"},   64'(done_busrq), 64'd0);
    check({name, " done_busy"},    64'(done_busy),  64'd1);
    check({name, " busy_after"},   64'(after_busy), 64'd0);
    check({name, " writes"},       64'(nwr),        64'(LEN));
    dup = 0;
    bad = 0;
    for (int i = 0; i < 512; i++) begin
      if (i < LEN) begin
        sa = base + 10'(i);
        if (wcnt[i] != 1) dup++;
        if (dst_mem[i] !== src_mem[sa]) bad++;
      end else if (wcnt[i] != 0) begin
        dup++;
      end
    end
    check({name, " write_once"}, 64'(dup), 64'd0);
    check({name, " data"},       64'(bad), 64'd0);
    repeat (2) @(negedge I_CLK);
    check({name, " idle_outs"}, all_outs(), 64'd0);
  endtask

  initial begin
    int         gd, da, dl;
    logic [9:0] b;

    I_RSTn = 1'b1; I_START = 1'b0; I_BUSAK = 1'b0; I_SRC_BASE = '0;
    for (int i = 0; i < 1024; i++) src_mem[i] = 8'(i);
    #2 I_RSTn = 1'b0;
    #1 check("reset outs", all_outs(), 64'd0);
    repeat (2) @(negedge I_CLK);
    check("reset held outs", all_outs(), 64'd0);
    I_RSTn = 1'b1;
    repeat (2) @(negedge I_CLK);

    // Basic copy: source holds addr[7:0].
    run_xfer("basic", 10'h000, 1, -1, 0, 1'b0, -1);
    check("basic d1",   64'(dst_mem[1]),   64'h01);
    check("basic d255", 64'(dst_mem[255]), 64'hFF);
    check("basic d383", 64'(dst_mem[383]), 64'h7F);

    for (int i = 0; i < 1024; i++) src_mem[i] = 8'($urandom_range(1, 255));

    run_xfer("wrap", 10'h300, 1, -1, 0, 1'b0, -1);
    check("wrap d255", 64'(dst_mem[255]), 64'(src_mem[10'h3FF]));
    check("wrap d256", 64'(dst_mem[256]), 64'(src_mem[10'h000]));
    check("wrap d383", 64'(dst_mem[383]), 64'(src_mem[10'h07F]));

    run_xfer("delay", 10'(32'($urandom)), 20, -1, 0, 1'b0, -1);

    b = 10'h155;
    run_xfer("drop", b, 1, 100, 10, 1'b0, -1);
    check("drop d100", 64'(dst_mem[100]), 64'(src_mem[b + 10'd100]));
    check("drop d101", 64'(dst_mem[101]), 64'(src_mem[b + 10'd101]));

    run_xfer("lastdrop", 10'h3C0, 2, LEN - 1, 4, 1'b0, -1);
    run_xfer("spur", 10'h010, 3, -1, 0, 1'b1, -1);
    run_xfer("after_spur", 10'h020, 0, -1, 0, 1'b0, -1);
    run_xfer("rst", 10'h040, 1, -1, 0, 1'b0, 200);
    repeat (2) @(negedge I_CLK);
    run_xfer("after_rst", 10'h050, 1, -1, 0, 1'b0, -1);

    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 1024; i++) src_mem[i] = 8'($urandom_range(1, 255));
      b  = 10'(32'($urandom));
      gd = $urandom_range(0, 8);
      da = ($urandom_range(0, 1) == 1) ? $urandom_range(0, LEN - 1) : -1;
      dl = $urandom_range(1, 12);
      run_xfer($sformatf("rand%0d", r), b, gd, da, dl, 1'b0, -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dkong_obj_dma.md
# dkong_obj_dma

Object-RAM copy engine for the video subsystem. When the frame-start strobe rises, it requests the CPU bus and waits for the grant. It then streams `LEN` bytes from CPU-side work RAM (a 1024×8 CE-gated single-port RAM) into the sprite line-buffer source RAM (a 512×8 port), one byte per clock. Finally it releases the bus. It replaces the 8257 DMA sequencing and sits between the CPU bus mux and the two BRAM wrappers.

## Interface
Parameters:
- `LEN`, 384: bytes copied per transfer, 1..512.
- `SRC_AW`, 10: source address width.
- `DST_AW`, 9: destination address width.

Ports:
- `I_CLK`  in  1  single clock for all logic.
- `I_RSTn`  in  1  reset, asynchronous, active-low.
- `I_START`  in  1  frame-start level; its rising edge triggers a transfer.
- `I_SRC_BASE`  in  `SRC_AW`  first source address, sampled on the accepted edge.
- `O_BUSRQ`  out  1  CPU bus request.
- `I_BUSAK`  in  1  CPU bus grant.
- `O_SRC_ADDR`  out  `SRC_AW`  source RAM address.
- `O_SRC_CE`  out  1  source RAM CE.
- `I_SRC_D`  in  8  source RAM read data (registered RAM output, gated to 0 by CE).
- `O_DST_ADDR`  out  `DST_AW`  destination address.
- `O_DST_D`  out  8  destination write data.
- `O_DST_CE`  out  1  destination CE.
- `O_DST_WE`  out  1  destination WE.
- `O_BUSY`  out  1  high from accepted edge until release.
- `O_DONE`  out  1  one-cycle pulse at completion.

## Operation
- **Edge detection.** A register holds last `I_START`. A rising edge is accepted only in IDLE; edges seen in any other state are dropped, not queued.
- **IDLE.** All outputs low. On an accepted edge: latch `I_SRC_BASE`, clear the counters, go to REQ.
- **REQ.** `O_BUSRQ`=1. Wait indefinitely for `I_BUSAK`=1, then go to XFER.
- **XFER.** Each cycle: `O_SRC_CE`=1, drive `O_SRC_ADDR`=base+rd_cnt (mod 2^`SRC_AW`, wraps 0x3FF→0x000), then increment rd_cnt.
  - When rd_cnt reaches `LEN`, go to DRAIN.
  - If `I_BUSAK` is sampled 0, go to PDRAIN.
- **Write side.** Runs one cycle behind the read side. When a read was issued in the previous cycle: `O_DST_CE`=`O_DST_WE`=1, `O_DST_ADDR`=wr_cnt, then increment wr_cnt.
- **Write data.** `O_DST_D` = `I_SRC_D` as a combinational pass-through.
- **Source CE must stay high through the write.** `O_SRC_CE` remains 1, with the address held, in the cycle the last in-flight byte is written. The source wrapper zeroes its output whenever CE is low, so dropping CE early would write 0.
- **DRAIN.** Last write occurs; `O_SRC_CE` is held. Go to DONE.
- **PDRAIN.** In-flight write completes, `O_SRC_CE` is held, `O_BUSRQ` stays 1. Go to REQ; resume at rd_cnt with no byte skipped or duplicated.
- **DONE.** `O_DONE`=1 for one cycle, `O_BUSRQ`=0, `O_BUSY`=0 the following cycle. Return to IDLE.
- **Counters.** rd_cnt and wr_cnt are `DST_AW`+1 bits wide; wr_cnt never exceeds rd_cnt.
- **Output registers.** All outputs are registered except `O_DST_D`.

## Timing
- **Reset values.** Every output is 0; state is IDLE; the edge register is 0. Asserting reset mid-transfer drops `O_BUSRQ` asynchronously and the transfer is lost.
- **Request latency.** Edge sampled at cycle 0 → `O_BUSRQ`=`O_BUSY`=1 in cycle 1.
- **Grant to first read.** `I_BUSAK` sampled 1 at cycle k → first source address in cycle k+1.
- **Read-to-write latency.** Byte i is read in cycle k+1+i and written in cycle k+2+i.
- **Completion, uninterrupted transfer.**
  - Last write in cycle k+`LEN`+1.
  - `O_DONE` in cycle k+`LEN`+2, with `O_BUSRQ` low in that same cycle.
  - Bus is held for `LEN`+2 cycles after the grant.
- **Throughput.** One byte per clock while the grant is held.
- **Simultaneous events.** Grant lost in the same cycle the last read issues → DRAIN takes priority; no PDRAIN.

## Structure
- A shared package `dkong_pkg` holds:
  - the state enum (IDLE, REQ, XFER, DRAIN, PDRAIN, DONE);
  - the default constants `OBJ_DMA_LEN=384`, `OBJ_SRC_AW=10`, `OBJ_DST_AW=9`.
- One flat module; no sub-module is needed. The BRAM wrappers are instantiated by the parent, not inside this block.

## Test plan
- **Basic copy.** Base 0x000, source preloaded with addr[7:0], grant 1 cycle after request → dest[i]=i[7:0] for i<384; `O_DONE` at grant+386; `O_BUSRQ` low the same cycle.
- **Address wrap.** Base 0x300 → dest[255]=src[0x3FF], dest[256]=src[0x000]; dest[383]=src[0x07F].
- **Delayed grant.** `I_BUSAK` 20 cycles after `O_BUSRQ` → no source CE before the grant; contents as in the basic copy.
- **Grant drop mid-transfer.**
  - Drop `I_BUSAK` after byte 100 is read, for 10 cycles → byte 100 is written correctly (not 0) while CE is held.
  - Reads resume at 101; no duplicate or skipped writes; total writes = 384.
- **Edges while busy.** Second `I_START` edge during XFER → ignored; exactly one `O_DONE`; next edge after IDLE starts a new transfer.
- **Reset mid-transfer.** `I_RSTn` low at byte 200 → all outputs 0 immediately; after release, a new edge performs a full 384-byte copy.
